bus_dma: RTL and testbench
==========================

BUS_DMA -- requirements
Module: bus_dma

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset; ports clk and rst.
REQ-002 SHALL provide these ports; all widths in bits.
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous active-high reset
- wr  input  1  CPU config write strobe, one cycle per write
- waddr  input  32  CPU config write address; only bits [3:2] decoded
- wdata  input  32  CPU config write data
- rd  input  1  CPU config read strobe
- raddr  input  32  CPU config read address; only bits [3:2] decoded
- rdata  output  32  CPU config read data, valid the cycle after rd
- m_wr  output  1  bus-master write strobe
- m_waddr  output  32  bus-master write address
- m_wdata  output  32  bus-master write data
- m_rd  output  1  bus-master read strobe
- m_raddr  output  32  bus-master read address
- m_rdata  input  32  bus-master read data, valid the cycle after m_rd
- irq  output  1  level interrupt, equals the DONE status bit
REQ-003 SHALL use these parameters:
- ADDR_STEP, default 4, byte increment per word
- LEN_WIDTH, default 16, width of the word-count register

Function
REQ-004 Register map, selected by address bits [3:2]:
- 0 SRC: R/W, 32 bits
- 1 DST: R/W, 32 bits
- 2 LEN: R/W, LEN_WIDTH bits, zero-extended on read
- 3 CTRL/STAT: write bit0 START, bit1 DONE_CLR, bit2 ABORT; read bit0 BUSY, bit1 DONE, bits[31:2] 0
REQ-005 Config reads SHALL be registered, one-cycle latency; rdata SHALL be 0 in every cycle not following an rd.
REQ-006 The FSM SHALL have states IDLE, READ, CAPTURE, WRITE; BUSY is 1 in every state except IDLE.
REQ-007 IDLE->READ on START when LEN!=0; the working copies cur_src, cur_dst and remaining load from SRC, DST and LEN.
REQ-008 START with LEN==0 SHALL stay in IDLE, set DONE the next cycle, and issue no bus transaction.
REQ-009 READ: m_rd=1 and m_raddr=cur_src for exactly one cycle, then ->CAPTURE.
REQ-010 CAPTURE: latch m_rdata into the data register, then ->WRITE.
REQ-011 WRITE: m_wr=1, m_waddr=cur_dst, m_wdata=latched data for one cycle; in the same cycle cur_src and cur_dst += ADDR_STEP and remaining -= 1.
- remaining becomes 0: ->IDLE and DONE is set.
- otherwise: ->READ.
REQ-012 Each word SHALL therefore take exactly 3 cycles; m_rd and m_wr SHALL never be asserted in the same cycle.
REQ-013 Address increments SHALL wrap modulo 2^32 with no error indication.
REQ-014 START while BUSY SHALL be ignored; the transfer continues unchanged.
REQ-015 SRC, DST and LEN writes while BUSY SHALL update the registers but not the working copies of the active transfer.
REQ-016 ABORT while BUSY SHALL force IDLE next cycle; DONE is not set; no further m_rd or m_wr is issued.
- An m_wr already asserted in the abort cycle completes.
- ABORT while IDLE has no effect.
REQ-017 DONE SHALL stay set until DONE_CLR; if DONE_CLR and the DONE-setting event occur in the same cycle, set wins.
REQ-018 START and DONE_CLR written together SHALL clear DONE and start the transfer.
REQ-019 When not asserted, m_waddr, m_wdata and m_raddr SHALL hold their last values.

Reset
REQ-020 On rst=1, immediately and asynchronously:
- SRC, DST, LEN, the working copies and the data register = 0
- state = IDLE
- BUSY, DONE, irq, m_rd, m_wr, rdata = 0
- m_raddr, m_waddr, m_wdata = 0
REQ-021 Reset mid-transfer SHALL abandon the transfer with no further bus strobes after rst asserts; operation resumes on the first clk edge after rst deasserts.

Verification
REQ-022 SRC=0x0100_0000, DST=0x0100_0100, LEN=3, START; memory model returns 0xA0,0xA1,0xA2 -> three m_rd/m_wr pairs 3 cycles apart, writes to 0x0100_0100/104/108 with matching data, DONE=irq=1 9 cycles after START, BUSY=0.
REQ-023 LEN=0, START -> no m_rd/m_wr, DONE=1 next cycle; DONE_CLR -> DONE=0.
REQ-024 SRC=0xFFFF_FFFC, LEN=2 -> m_raddr sequence 0xFFFF_FFFC, 0x0000_0000.
REQ-025 LEN=4, START, then START again and a new LEN=1 during word 2 -> exactly 4 words transferred; reading LEN returns 1.
REQ-026 ABORT in the CAPTURE cycle of word 2 -> no m_wr for word 2, BUSY=0 next cycle, DONE=0.
REQ-027 rst pulse during WRITE -> m_wr=0 immediately, all registers read 0 after release.

Source files
------------

// File: rtl/bus_dma_if.sv
// Signal bundle for bus_dma: CPU configuration port, bus-master port and interrupt.
// The slave modport is the DMA's view; master is the view of whoever drives it.
interface bus_dma_if;
  logic        wr;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic        rd;
  logic [31:0] raddr;
  logic [31:0] rdata;
  logic        m_wr;
  logic [31:0] m_waddr;
  logic [31:0] m_wdata;
  logic        m_rd;
  logic [31:0] m_raddr;
  logic [31:0] m_rdata;
  logic        irq;

  modport slave (
    input  wr, waddr, wdata, rd, raddr, m_rdata,
    output rdata, m_wr, m_waddr, m_wdata, m_rd, m_raddr, irq
  );

  modport master (
    output wr, waddr, wdata, rd, raddr, m_rdata,
    input  rdata, m_wr, m_waddr, m_wdata, m_rd, m_raddr, irq
  );
endinterface

// File: rtl/bus_dma.sv
// Single-channel memory-to-memory DMA: read one word, capture it, write it, repeat
// for LEN words. Configured and monitored through a four-register CPU port.
//
// state   | meaning
// IDLE    | no transfer active, BUSY=0
// READ    | m_rd issued at cur_src
// CAPTURE | m_rdata latched into data_reg
// WRITE   | m_wr issued at cur_dst, working copies advance
module bus_dma #(
  parameter int ADDR_STEP = 4,
  parameter int LEN_WIDTH = 16
) (
  input  logic     clk,
  input  logic     rst,
  bus_dma_if.slave bus
);

  typedef enum logic [1:0] {IDLE, READ, CAPTURE, WRITE} state_t;

  state_t               state, state_nxt;
  logic [31:0]          src, dst, cur_src, cur_dst, data_reg;
  logic [31:0]          raddr_hold, waddr_hold, wdata_hold, rdata_q;
  logic [LEN_WIDTH-1:0] len, remaining;
  logic                 done;
  logic                 ctrl_wr, start, done_clr, abort, busy;
  logic                 start_go, done_set, last_word;
  logic [31:0]          rd_mux;
  logic                 unused_addr_bits;

  assign unused_addr_bits = ^{bus.waddr[31:4], bus.waddr[1:0],
                              bus.raddr[31:4], bus.raddr[1:0]};

  assign ctrl_wr   = bus.wr && (bus.waddr[3:2] == 2'd3);
  assign start     = ctrl_wr && bus.wdata[0];
  assign done_clr  = ctrl_wr && bus.wdata[1];
  assign abort     = ctrl_wr && bus.wdata[2];
  assign busy      = (state != IDLE);
  assign last_word = (remaining == LEN_WIDTH'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start_go  = 1'b0;
    done_set  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            state_nxt = READ;
            start_go  = 1'b1;
          end else begin
            done_set = 1'b1;
          end
        end
      end
      READ:    state_nxt = CAPTURE;
      CAPTURE: state_nxt = WRITE;
      WRITE: begin
        if (last_word) begin
          state_nxt = IDLE;
          done_set  = 1'b1;
        end else begin
          state_nxt = READ;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Abort wins over a completing last word: the transfer is not reported done.
    if (abort && busy) begin
      state_nxt = IDLE;
      done_set  = 1'b0;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (bus.raddr[3:2])
      2'd0: rd_mux = src;
      2'd1: rd_mux = dst;
      2'd2: rd_mux = 32'(len);
      2'd3: rd_mux = {30'd0, done, busy};
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src        <= '0;
      dst        <= '0;
      len        <= '0;
      cur_src    <= '0;
      cur_dst    <= '0;
      remaining  <= '0;
      data_reg   <= '0;
      raddr_hold <= '0;
      waddr_hold <= '0;
      wdata_hold <= '0;
      done       <= 1'b0;
      rdata_q    <= '0;
    end else begin
      if (bus.wr) begin
        case (bus.waddr[3:2])
          2'd0:    src <= bus.wdata;
          2'd1:    dst <= bus.wdata;
          2'd2:    len <= bus.wdata[LEN_WIDTH-1:0];
          default: ;
        endcase
      end
      if (start_go) begin
        cur_src   <= src;
        cur_dst   <= dst;
        remaining <= len;
      end
      if (state == READ) raddr_hold <= cur_src;
      if (state == CAPTURE) data_reg <= bus.m_rdata;
      if (state == WRITE) begin
        waddr_hold <= cur_dst;
        wdata_hold <= data_reg;
        cur_src    <= cur_src + 32'(ADDR_STEP);
        cur_dst    <= cur_dst + 32'(ADDR_STEP);
        remaining  <= remaining - LEN_WIDTH'(1);
      end
      if (done_set)      done <= 1'b1;
      else if (done_clr) done <= 1'b0;
      rdata_q <= bus.rd ? rd_mux : 32'd0;
    end
  end

  // Bus addresses/data are live during their strobe and otherwise hold the last value.
  assign bus.m_rd    = (state == READ);
  assign bus.m_wr    = (state == WRITE);
  assign bus.m_raddr = (state == READ)  ? cur_src  : raddr_hold;
  assign bus.m_waddr = (state == WRITE) ? cur_dst  : waddr_hold;
  assign bus.m_wdata = (state == WRITE) ? data_reg : wdata_hold;
  assign bus.rdata   = rdata_q;
  assign bus.irq     = done;

endmodule

// File: tb/tb_bus_dma.sv
// Self-checking bench for bus_dma: register vector table, directed corner cases and
// randomized transfers compared against a word-list model of each transfer.
module tb_bus_dma;
  localparam int STEP = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bus_dma_if bus_if();

  bus_dma #(.ADDR_STEP(STEP), .LEN_WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int overlap  = 0;

  logic [31:0] mem_base = '0;
  logic [31:0] mem_off  = '0;
  logic [31:0] rd_addr_q[$];
  int          rd_cyc_q[$];
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          wr_cyc_q[$];

  logic [31:0] exp_src, exp_dst, exp_off;
  int          exp_len;
  int          start_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory word at address a is mem_off plus the word index from mem_base.
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return mem_off + ((a - mem_base) >> 2);
  endfunction

  // Bus monitor and memory responder, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      bus_if.m_rdata = '0;
    end else begin
      if (bus_if.m_rd) begin
        rd_addr_q.push_back(bus_if.m_raddr);
        rd_cyc_q.push_back(cyc);
        bus_if.m_rdata = mem_val(bus_if.m_raddr);
      end
      if (bus_if.m_wr) begin
        wr_addr_q.push_back(bus_if.m_waddr);
        wr_data_q.push_back(bus_if.m_wdata);
        wr_cyc_q.push_back(cyc);
      end
      if (bus_if.m_rd && bus_if.m_wr) overlap++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cpu_write(input logic [31:0] addr, input logic [31:0] data);
    bus_if.wr    = 1'b1;
    bus_if.waddr = addr;
    bus_if.wdata = data;
    @(posedge clk);
    #1;
    bus_if.wr = 1'b0;
  endtask

  task automatic cpu_read(input logic [31:0] addr, output logic [31:0] data);
    bus_if.rd    = 1'b1;
    bus_if.raddr = addr;
    @(posedge clk);
    #1;
    bus_if.rd = 1'b0;
    data = bus_if.rdata;
  endtask

  task automatic clear_q();
    rd_addr_q.delete();
    rd_cyc_q.delete();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    overlap = 0;
  endtask

  task automatic start_xfer(input logic [31:0] s, input logic [31:0] d,
                            input int l, input logic [31:0] off);
    cpu_write(32'h0, s);
    cpu_write(32'h4, d);
    cpu_write(32'h8, 32'(l));
    mem_base = s;
    mem_off  = off;
    exp_src  = s;
    exp_dst  = d;
    exp_len  = l;
    exp_off  = off;
    clear_q();
    cpu_write(32'hC, 32'h3);
    start_cyc = cyc;
  endtask

  task automatic wait_done(input int budget, output int done_at);
    int k = 0;
    while (bus_if.irq !== 1'b1 && k < budget) begin
      tick(1);
      k++;
    end
    chk("done_within_budget", 32'(bus_if.irq), 32'd1);
    done_at = cyc;
  endtask

  task automatic check_xfer(input string tag);
    int          done_at;
    logic [31:0] r;
    wait_done(3 * exp_len + 10, done_at);
    chk($sformatf("%s_done_cycle", tag), 32'(done_at - start_cyc), 32'(3 * exp_len));
    tick(2);
    chk($sformatf("%s_n_reads", tag), 32'(rd_addr_q.size()), 32'(exp_len));
    chk($sformatf("%s_n_writes", tag), 32'(wr_addr_q.size()), 32'(exp_len));
    for (int i = 0; i < exp_len; i++) begin
      if (i < rd_addr_q.size()) begin
        chk($sformatf("%s_rd_addr%0d", tag, i), rd_addr_q[i], exp_src + 32'(i * STEP));
        chk($sformatf("%s_rd_cyc%0d", tag, i), 32'(rd_cyc_q[i] - start_cyc), 32'(3 * i));
      end
      if (i < wr_addr_q.size()) begin
        chk($sformatf("%s_wr_addr%0d", tag, i), wr_addr_q[i], exp_dst + 32'(i * STEP));
        chk($sformatf("%s_wr_data%0d", tag, i), wr_data_q[i], exp_off + 32'(i));
        chk($sformatf("%s_wr_cyc%0d", tag, i), 32'(wr_cyc_q[i] - start_cyc), 32'(3 * i + 2));
      end
    end
    chk($sformatf("%s_rd_wr_overlap", tag), 32'(overlap), 32'd0);
    cpu_read(32'hC, r);
    chk($sformatf("%s_stat", tag), r, 32'h2);
  endtask

  typedef struct {
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [31:0] raddr;
    logic [31:0] exp;
  } reg_vec_t;

  reg_vec_t vecs[7];

  initial begin
    logic [31:0] r;
    int          nr;

    vecs[0] = '{32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678};
    vecs[1] = '{32'h0000_0004, 32'hCAFE_F00D, 32'hFFFF_0004, 32'hCAFE_F00D};
    vecs[2] = '{32'h0000_0008, 32'hFFFF_ABCD, 32'h0000_0008, 32'h0000_ABCD};
    vecs[3] = '{32'hFFFF_FFF0, 32'h0BAD_0001, 32'h0000_0000, 32'h0BAD_0001};
    vecs[4] = '{32'h0000_000C, 32'h0000_0004, 32'h0000_000C, 32'h0000_0000};
    vecs[5] = '{32'h0000_0008, 32'h0000_0000, 32'h0000_0008, 32'h0000_0000};
    vecs[6] = '{32'h0000_0007, 32'h0000_0042, 32'h0000_0005, 32'h0000_0042};

    bus_if.wr = 1'b0;
    bus_if.waddr = '0;
    bus_if.wdata = '0;
    bus_if.rd = 1'b0;
    bus_if.raddr = '0;

    #1 rst = 1'b1;
    #18;
    chk("rst_m_rd", 32'(bus_if.m_rd), 32'd0);
    chk("rst_m_wr", 32'(bus_if.m_wr), 32'd0);
    chk("rst_irq", 32'(bus_if.irq), 32'd0);
    chk("rst_rdata", bus_if.rdata, 32'd0);
    chk("rst_m_raddr", bus_if.m_raddr, 32'd0);
    chk("rst_m_waddr", bus_if.m_waddr, 32'd0);
    chk("rst_m_wdata", bus_if.m_wdata, 32'd0);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    for (int a = 0; a < 4; a++) begin
      cpu_read(32'(a * 4), r);
      chk($sformatf("rst_reg%0d", a), r, 32'd0);
    end

    // Register vector table.
    for (int i = 0; i < 7; i++) begin
      cpu_write(vecs[i].waddr, vecs[i].wdata);
      cpu_read(vecs[i].raddr, r);
      chk($sformatf("vec%0d_read", i), r, vecs[i].exp);
      tick(1);
      chk($sformatf("vec%0d_rdata_idle", i), bus_if.rdata, 32'd0);
    end

    // Three-word reference transfer.
    start_xfer(32'h0100_0000, 32'h0100_0100, 3, 32'hA0);
    check_xfer("basic");
    chk("basic_irq", 32'(bus_if.irq), 32'd1);

    // DONE_CLR, then zero-length start.
    cpu_write(32'hC, 32'h2);
    chk("clr_irq", 32'(bus_if.irq), 32'd0);
    cpu_write(32'h8, 32'h0);
    clear_q();
    cpu_write(32'hC, 32'h1);
    chk("len0_done_next", 32'(bus_if.irq), 32'd1);
    cpu_read(32'hC, r);
    chk("len0_stat", r, 32'h2);
    tick(3);
    chk("len0_no_rd", 32'(rd_addr_q.size()), 32'd0);
    chk("len0_no_wr", 32'(wr_addr_q.size()), 32'd0);
    cpu_write(32'hC, 32'h2);
    chk("len0_clr", 32'(bus_if.irq), 32'd0);
    cpu_write(32'hC, 32'h2);
    cpu_write(32'hC, 32'h3);
    chk("len0_set_wins", 32'(bus_if.irq), 32'd1);

    // Source address wrap.
    start_xfer(32'hFFFF_FFFC, 32'h2000_0000, 2, 32'h55);
    check_xfer("wrap");

    // START and new LEN while busy are ignored by the active transfer.
    start_xfer(32'h0000_4000, 32'h0000_8000, 4, 32'h300);
    tick(3);
    cpu_write(32'hC, 32'h1);
    cpu_write(32'h8, 32'h1);
    cpu_write(32'h0, 32'hDEAD_0000);
    check_xfer("restart");
    cpu_read(32'h8, r);
    chk("restart_len_reg", r, 32'h1);
    cpu_read(32'h0, r);
    chk("restart_src_reg", r, 32'hDEAD_0000);

    // Abort in the CAPTURE cycle of word 2.
    start_xfer(32'h0000_1000, 32'h0000_2000, 4, 32'h10);
    tick(4);
    cpu_write(32'hC, 32'h4);
    chk("abort_no_wr", 32'(bus_if.m_wr), 32'd0);
    cpu_read(32'hC, r);
    chk("abort_stat", r, 32'h0);
    tick(6);
    chk("abort_n_reads", 32'(rd_addr_q.size()), 32'd2);
    chk("abort_n_writes", 32'(wr_addr_q.size()), 32'd1);
    chk("abort_irq", 32'(bus_if.irq), 32'd0);

    // Reset pulse during WRITE.
    start_xfer(32'h0000_3000, 32'h0000_5000, 3, 32'h77);
    tick(2);
    chk("rstmid_in_write", 32'(bus_if.m_wr), 32'd1);
    rst = 1'b1;
    #1;
    chk("rstmid_m_wr", 32'(bus_if.m_wr), 32'd0);
    chk("rstmid_m_rd", 32'(bus_if.m_rd), 32'd0);
    chk("rstmid_m_waddr", bus_if.m_waddr, 32'd0);
    chk("rstmid_m_wdata", bus_if.m_wdata, 32'd0);
    tick(2);
    rst = 1'b0;
    clear_q();
    for (int a = 0; a < 4; a++) begin
      cpu_read(32'(a * 4), r);
      chk($sformatf("rstmid_reg%0d", a), r, 32'd0);
    end
    tick(4);
    chk("rstmid_no_strobes", 32'(rd_addr_q.size() + wr_addr_q.size()), 32'd0);

    // Randomized transfers with random register writes while busy.
    for (int t = 0; t < 12; t++) begin
      start_xfer($urandom, $urandom, int'($urandom_range(1, 6)), $urandom);
      if ($urandom_range(0, 1) == 1) begin
        tick(int'($urandom_range(0, 2)));
        nr = int'($urandom_range(0, 2));
        cpu_write(32'(nr * 4), $urandom);
      end
      check_xfer($sformatf("rand%0d", t));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
